// File: rtl/sc_max7219_rx_if.sv
// Signal bundle for sc_max7219_rx: MAX7219 serial link, row read port and the mirrored state.
// SC_MAX7219RX_DOUT_EN adds the daisy-chain output.
interface sc_max7219_rx_if;
    logic       SC_MAX7219RX_din_In;
    logic       SC_MAX7219RX_ncs_In;
    logic       SC_MAX7219RX_sclk_In;
    logic [2:0] SC_MAX7219RX_rowaddr_InBUS;
    logic [7:0] SC_MAX7219RX_rowraw_OutBUS;
    logic [7:0] SC_MAX7219RX_rowlit_OutBUS;
    logic [3:0] SC_MAX7219RX_intensity_OutBUS;
    logic [2:0] SC_MAX7219RX_scanlimit_OutBUS;
    logic [7:0] SC_MAX7219RX_decode_OutBUS;
    logic       SC_MAX7219RX_shutdown_Out;
    logic       SC_MAX7219RX_test_Out;
    logic       SC_MAX7219RX_frameValid_Out;
    logic [3:0] SC_MAX7219RX_frameAddr_OutBUS;
    logic [7:0] SC_MAX7219RX_frameData_OutBUS;
    logic       SC_MAX7219RX_frameError_Out;
`ifdef SC_MAX7219RX_DOUT_EN
    logic       SC_MAX7219RX_dout_Out;

    modport slave (
        input  SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
               SC_MAX7219RX_rowaddr_InBUS,
        output SC_MAX7219RX_rowraw_OutBUS, SC_MAX7219RX_rowlit_OutBUS,
               SC_MAX7219RX_intensity_OutBUS, SC_MAX7219RX_scanlimit_OutBUS,
               SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_test_Out,
               SC_MAX7219RX_frameValid_Out, SC_MAX7219RX_frameAddr_OutBUS,
               SC_MAX7219RX_frameData_OutBUS, SC_MAX7219RX_frameError_Out,
               SC_MAX7219RX_dout_Out
    );

    modport master (
        output SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
               SC_MAX7219RX_rowaddr_InBUS,
        input  SC_MAX7219RX_rowraw_OutBUS, SC_MAX7219RX_rowlit_OutBUS,
               SC_MAX7219RX_intensity_OutBUS, SC_MAX7219RX_scanlimit_OutBUS,
               SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_test_Out,
               SC_MAX7219RX_frameValid_Out, SC_MAX7219RX_frameAddr_OutBUS,
               SC_MAX7219RX_frameData_OutBUS, SC_MAX7219RX_frameError_Out,
               SC_MAX7219RX_dout_Out
    );
`else
    modport slave (
        input  SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
               SC_MAX7219RX_rowaddr_InBUS,
        output SC_MAX7219RX_rowraw_OutBUS, SC_MAX7219RX_rowlit_OutBUS,
               SC_MAX7219RX_intensity_OutBUS, SC_MAX7219RX_scanlimit_OutBUS,
               SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_test_Out,
               SC_MAX7219RX_frameValid_Out, SC_MAX7219RX_frameAddr_OutBUS,
               SC_MAX7219RX_frameData_OutBUS, SC_MAX7219RX_frameError_Out
    );

    modport master (
        output SC_MAX7219RX_din_In, SC_MAX7219RX_ncs_In, SC_MAX7219RX_sclk_In,
               SC_MAX7219RX_rowaddr_InBUS,
        input  SC_MAX7219RX_rowraw_OutBUS, SC_MAX7219RX_rowlit_OutBUS,
               SC_MAX7219RX_intensity_OutBUS, SC_MAX7219RX_scanlimit_OutBUS,
               SC_MAX7219RX_decode_OutBUS, SC_MAX7219RX_shutdown_Out, SC_MAX7219RX_test_Out,
               SC_MAX7219RX_frameValid_Out, SC_MAX7219RX_frameAddr_OutBUS,
               SC_MAX7219RX_frameData_OutBUS, SC_MAX7219RX_frameError_Out
    );
`endif
endinterface

// File: rtl/sc_max7219_rx.sv
// MAX7219 3-wire link responder: oversamples DIN/NCS/SCLK, deserialises 16-bit frames and
// mirrors the MAX7219 register file. Optional daisy-chain output under SC_MAX7219RX_DOUT_EN.
module sc_max7219_rx #(
    parameter int unsigned SYNC_STAGES = 2  // legal 2..3
) (
    input logic             SC_MAX7219RX_CLOCK_50,
    input logic             SC_MAX7219RX_RESET_InHigh,
    sc_max7219_rx_if.slave  bus
);
    typedef enum logic [1:0] {StWait, StIdle, StShift, StLatch} state_e;

    logic clk, rst;
    assign clk = SC_MAX7219RX_CLOCK_50;
    assign rst = SC_MAX7219RX_RESET_InHigh;

    logic [SYNC_STAGES-1:0] din_sync_q, ncs_sync_q, sclk_sync_q;
    logic                   ncs_prev_q, sclk_prev_q;
    logic                   din_s, ncs_s, sclk_s;
    logic                   ncs_fall, ncs_rise, sclk_rise;

    state_e          state_q, state_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic [7:0][7:0] rows_q, rows_d;
    logic [7:0]      decode_q, decode_d;
    logic [3:0]      intensity_q, intensity_d;
    logic [2:0]      scanlim_q, scanlim_d;
    logic            shutdown_q, shutdown_d;
    logic            test_q, test_d;
    logic [3:0]      faddr_q, faddr_d;
    logic [7:0]      fdata_q, fdata_d;
    logic            ferr_q, ferr_d;
    logic [7:0]      rowraw_q, rowraw_d;
    logic [7:0]      rowlit_q, rowlit_d;
`ifdef SC_MAX7219RX_DOUT_EN
    logic [15:0]     dly_q, dly_d;
`endif

    assign din_s     = din_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ncs_fall  = ncs_prev_q & ~ncs_s;
    assign ncs_rise  = ~ncs_prev_q & ncs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;

    // NCS resets low so a frame still open at reset release keeps the FSM in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_sync_q  <= '0;
            ncs_sync_q  <= '0;
            sclk_sync_q <= '0;
            ncs_prev_q  <= 1'b0;
            sclk_prev_q <= 1'b0;
        end else begin
            din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], bus.SC_MAX7219RX_din_In};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.SC_MAX7219RX_ncs_In};
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SC_MAX7219RX_sclk_In};
            ncs_prev_q  <= ncs_s;
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        rows_d      = rows_q;
        decode_d    = decode_q;
        intensity_d = intensity_q;
        scanlim_d   = scanlim_q;
        shutdown_d  = shutdown_q;
        test_d      = test_q;
        faddr_d     = faddr_q;
        fdata_d     = fdata_q;
        ferr_d      = 1'b0;
`ifdef SC_MAX7219RX_DOUT_EN
        dly_d       = dly_q;
`endif
        unique case (state_q)
            StWait: begin
                if (ncs_s) state_d = StIdle;
            end
            StIdle: begin
                if (ncs_fall) begin
                    cnt_d   = '0;
                    shift_d = '0;
`ifdef SC_MAX7219RX_DOUT_EN
                    dly_d   = '0;
`endif
                    state_d = StShift;
                end
            end
            StShift: begin
                if (ncs_rise) begin
                    if (cnt_q >= 5'd16) begin
                        state_d = StLatch;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (sclk_rise && !ncs_s) begin
                    shift_d = {shift_q[14:0], din_s};
`ifdef SC_MAX7219RX_DOUT_EN
                    dly_d   = {dly_q[14:0], din_s};
`endif
                    if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
                end
            end
            StLatch: begin
                faddr_d = shift_q[11:8];
                fdata_d = shift_q[7:0];
                case (shift_q[11:8])
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: rows_d[shift_q[10:8] - 3'd1] = shift_q[7:0];
                    4'h9:    decode_d    = shift_q[7:0];
                    4'hA:    intensity_d = shift_q[3:0];
                    4'hB:    scanlim_d   = shift_q[2:0];
                    4'hC:    shutdown_d  = ~shift_q[0];
                    4'hF:    test_d      = shift_q[0];
                    default: ;
                endcase
                state_d = StIdle;
            end
            default: state_d = StWait;
        endcase
    end

    always_comb begin
        rowraw_d = rows_q[bus.SC_MAX7219RX_rowaddr_InBUS];
        if (test_q)                                       rowlit_d = 8'hFF;
        else if (shutdown_q)                              rowlit_d = 8'h00;
        else if (bus.SC_MAX7219RX_rowaddr_InBUS > scanlim_q) rowlit_d = 8'h00;
        else                                              rowlit_d = rowraw_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StWait;
            cnt_q       <= '0;
            shift_q     <= '0;
            rows_q      <= '0;
            decode_q    <= '0;
            intensity_q <= '0;
            scanlim_q   <= '0;
            shutdown_q  <= 1'b1;
            test_q      <= 1'b0;
            faddr_q     <= '0;
            fdata_q     <= '0;
            ferr_q      <= 1'b0;
            rowraw_q    <= '0;
            rowlit_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            rows_q      <= rows_d;
            decode_q    <= decode_d;
            intensity_q <= intensity_d;
            scanlim_q   <= scanlim_d;
            shutdown_q  <= shutdown_d;
            test_q      <= test_d;
            faddr_q     <= faddr_d;
            fdata_q     <= fdata_d;
            ferr_q      <= ferr_d;
            rowraw_q    <= rowraw_d;
            rowlit_q    <= rowlit_d;
        end
    end

`ifdef SC_MAX7219RX_DOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dly_q <= '0;
        else     dly_q <= dly_d;
    end

    assign bus.SC_MAX7219RX_dout_Out = dly_q[15];
`endif

    assign bus.SC_MAX7219RX_rowraw_OutBUS    = rowraw_q;
    assign bus.SC_MAX7219RX_rowlit_OutBUS    = rowlit_q;
    assign bus.SC_MAX7219RX_intensity_OutBUS = intensity_q;
    assign bus.SC_MAX7219RX_scanlimit_OutBUS = scanlim_q;
    assign bus.SC_MAX7219RX_decode_OutBUS    = decode_q;
    assign bus.SC_MAX7219RX_shutdown_Out     = shutdown_q;
    assign bus.SC_MAX7219RX_test_Out         = test_q;
    assign bus.SC_MAX7219RX_frameValid_Out   = (state_q == StLatch);
    assign bus.SC_MAX7219RX_frameAddr_OutBUS = faddr_q;
    assign bus.SC_MAX7219RX_frameData_OutBUS = fdata_q;
    assign bus.SC_MAX7219RX_frameError_Out   = ferr_q;
endmodule
